// File: rtl/kernel3_fifo_srl_ctrl.sv
// ---------------------------------------------------------------------------
// kernel3_fifo_srl_ctrl
// First-word-fall-through FIFO for kernel3 inter-task streams. Payload is held
// in a shift-register array (maps to SRL primitives); the head word is read at
// index count-1. The control block provides full/empty handshakes, an
// occupancy count and programmable almost-full / almost-empty flags. All flags
// are registered from the next-state count, so no input reaches a flag
// combinationally.
//
// Optional feature (macro KERNEL3_FIFO_OREG_EN):
//   Adds a one-entry registered output stage after the array. Capacity becomes
//   DEPTH+1, if_dout comes from a flop, if_full_n tracks array fullness only,
//   if_num_data_valid counts array plus stage. Write-to-if_empty_n latency is
//   2 cycles (1 cycle without the stage).
//
// Ports:
//   clk                in   sole clock, rising edge
//   reset              in   synchronous reset, active-high
//   if_full_n          out  space available
//   if_write_ce        in   write clock-enable
//   if_write           in   write request
//   if_din             in   write data
//   if_empty_n         out  data available
//   if_read_ce         in   read clock-enable
//   if_read            in   read request (acknowledges if_dout)
//   if_dout            out  head-of-queue data
//   if_num_data_valid  out  current occupancy
//   if_almost_full     out  count >= AFULL_LEVEL
//   if_almost_empty    out  count <= AEMPTY_LEVEL
// ---------------------------------------------------------------------------
module kernel3_fifo_srl_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic                  if_almost_full,
  output logic                  if_almost_empty
);

  localparam int CW = ADDR_WIDTH + 1;

  // Storage (never reset)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Control state
  logic [CW-1:0]         arr_cnt_q, arr_cnt_d;
  logic [CW-1:0]         total_q, total_d;
  logic                  full_n_q, empty_n_q;
  logic                  afull_q, aempty_q;
  logic                  empty_n_d;

  logic                  push, pop, arr_pop;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] arr_head;

  assign push     = if_write & if_write_ce & full_n_q;
  // Head of the array sits at the oldest entry, count-1.
  assign rd_idx   = arr_cnt_q[ADDR_WIDTH-1:0] - 1'b1;
  assign arr_head = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
      mem_q[0] <= if_din;
    end
  end

`ifdef KERNEL3_FIFO_OREG_EN
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  stage_ld;

  // External pop acknowledges the stage; the stage refills from the array
  // whenever it is empty or being emptied this cycle.
  assign pop      = if_read & if_read_ce & ov_q;
  assign stage_ld = (arr_cnt_q != '0) & (~ov_q | pop);
  assign arr_pop  = stage_ld;

  always_comb begin
    ov_d = ov_q;
    if (stage_ld) begin
      ov_d = 1'b1;
    end else if (pop) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ov_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      ov_q <= ov_d;
      if (stage_ld) begin
        dout_q <= arr_head;
      end
    end
  end

  assign if_dout   = dout_q;
  assign total_d   = arr_cnt_d + {{(CW-1){1'b0}}, ov_d};
  assign empty_n_d = ov_d;
`else
  assign pop       = if_read & if_read_ce & empty_n_q;
  assign arr_pop   = pop;
  assign if_dout   = arr_head;
  assign total_d   = arr_cnt_d;
  assign empty_n_d = (total_d != '0);
`endif

  always_comb begin
    arr_cnt_d = arr_cnt_q;
    unique case ({push, arr_pop})
      2'b10:   arr_cnt_d = arr_cnt_q + 1'b1;
      2'b01:   arr_cnt_d = arr_cnt_q - 1'b1;
      default: arr_cnt_d = arr_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arr_cnt_q <= '0;
      total_q   <= '0;
      full_n_q  <= 1'b0;
      empty_n_q <= 1'b0;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
    end else begin
      arr_cnt_q <= arr_cnt_d;
      total_q   <= total_d;
      full_n_q  <= (arr_cnt_d != CW'(DEPTH));
      empty_n_q <= empty_n_d;
      afull_q   <= (total_d >= CW'(AFULL_LEVEL));
      aempty_q  <= (total_d <= CW'(AEMPTY_LEVEL));
    end
  end

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_almost_full    = afull_q;
  assign if_almost_empty   = aempty_q;
  assign if_num_data_valid = total_q;

endmodule

// File: tb/tb_kernel3_fifo_srl_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for kernel3_fifo_srl_ctrl, default build (no output
// stage, DEPTH=16, AFULL_LEVEL=14, AEMPTY_LEVEL=2). Directed sequences with
// hand-computed expectations plus a queue scoreboard for the mixed phase.
// ---------------------------------------------------------------------------
module tb_kernel3_fifo_srl_ctrl;

  localparam int DW     = 32;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 14;
  localparam int AEMPTY = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_full_n, if_empty_n;
  logic          if_write_ce, if_write, if_read_ce, if_read;
  logic [DW-1:0] if_din, if_dout;
  logic [AW:0]   if_num_data_valid;
  logic          if_almost_full, if_almost_empty;

  int checks = 0;
  int errors = 0;

  kernel3_fifo_srl_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFULL),
    .AEMPTY_LEVEL(AEMPTY)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .if_full_n        (if_full_n),
    .if_write_ce      (if_write_ce),
    .if_write         (if_write),
    .if_din           (if_din),
    .if_empty_n       (if_empty_n),
    .if_read_ce       (if_read_ce),
    .if_read          (if_read),
    .if_dout          (if_dout),
    .if_num_data_valid(if_num_data_valid),
    .if_almost_full   (if_almost_full),
    .if_almost_empty  (if_almost_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    if_write = 1'b1;
    if_din   = v;
    step();
    if_write = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [DW-1:0] v);
    check(tag, if_dout, v);
    if_read = 1'b1;
    step();
    if_read = 1'b0;
  endtask

  logic [DW-1:0] q[$];
  int            mcnt;
  logic          wr, rd, wce, rce, mpush, mpop;
  logic [DW-1:0] d;

  initial begin
    reset = 1'b1;
    if_write = 1'b0; if_read = 1'b0;
    if_write_ce = 1'b1; if_read_ce = 1'b1;
    if_din = '0;

    // Reset state
    repeat (3) step();
    check("rst_full_n",   if_full_n, 0);
    check("rst_empty_n",  if_empty_n, 0);
    check("rst_afull",    if_almost_full, 0);
    check("rst_aempty",   if_almost_empty, 1);
    check("rst_count",    if_num_data_valid, 0);

    reset = 1'b0;
    step();
    check("rel_full_n",   if_full_n, 1);
    check("rel_aempty",   if_almost_empty, 1);
    check("rel_count",    if_num_data_valid, 0);
    check("rel_empty_n",  if_empty_n, 0);

    // Fill 0x1..0x10 back-to-back
    if_write = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      if_din = DW'(i);
      step();
      check("fill_count",  if_num_data_valid, 64'(i));
      check("fill_afull",  if_almost_full, (i >= AFULL) ? 1 : 0);
      check("fill_full_n", if_full_n, (i == DEPTH) ? 0 : 1);
      check("fill_aempty", if_almost_empty, (i <= AEMPTY) ? 1 : 0);
    end
    if_din = 32'hFF;
    step();
    if_write = 1'b0;
    check("ovf_count",  if_num_data_valid, 16);
    check("ovf_full_n", if_full_n, 0);
    for (int i = 1; i <= DEPTH; i++) pop_expect("drain1", DW'(i));
    check("drain1_empty_n", if_empty_n, 0);
    check("drain1_count",   if_num_data_valid, 0);

    // Full FIFO with simultaneous write+read: pop wins, push blocked
    for (int i = 1; i <= DEPTH; i++) push_word(32'h20 + DW'(i));
    check("full2_full_n", if_full_n, 0);
    check("full2_head",   if_dout, 32'h21);
    if_write = 1'b1; if_din = 32'h99; if_read = 1'b1;
    step();
    if_read = 1'b0;
    check("simfull_count",  if_num_data_valid, 15);
    check("simfull_full_n", if_full_n, 1);
    step();
    if_write = 1'b0;
    check("retry_count",  if_num_data_valid, 16);
    for (int i = 2; i <= DEPTH; i++) pop_expect("drain2", 32'h20 + DW'(i));
    pop_expect("drain2_last", 32'h99);
    check("drain2_empty_n", if_empty_n, 0);

    // Empty FIFO with simultaneous write+read: read ignored
    if_write = 1'b1; if_din = 32'hA5; if_read = 1'b1;
    step();
    if_write = 1'b0; if_read = 1'b0;
    check("simemp_empty_n", if_empty_n, 1);
    check("simemp_dout",    if_dout, 32'hA5);
    check("simemp_count",   if_num_data_valid, 1);
    pop_expect("simemp_pop", 32'hA5);

    // Half full, then mixed traffic against a queue scoreboard
    q.delete();
    for (int i = 0; i < 8; i++) begin
      d = 32'h1000 + DW'(i);
      push_word(d);
      q.push_back(d);
    end
    for (int c = 0; c < 1000; c++) begin
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 50);
      wce = ($urandom_range(0, 9) != 0);
      rce = ($urandom_range(0, 9) != 0);
      d   = $urandom;
      mcnt  = q.size();
      mpush = wr & wce & (mcnt != DEPTH);
      mpop  = rd & rce & (mcnt != 0);
      if (mpop) check("rnd_dout", if_dout, q[0]);
      if_write = wr; if_write_ce = wce; if_din = d;
      if_read  = rd; if_read_ce  = rce;
      step();
      if (mpop)  void'(q.pop_front());
      if (mpush) q.push_back(d);
      mcnt = q.size();
      check("rnd_count",   if_num_data_valid, 64'(mcnt));
      check("rnd_full_n",  if_full_n,  (mcnt != DEPTH) ? 1 : 0);
      check("rnd_empty_n", if_empty_n, (mcnt != 0) ? 1 : 0);
      check("rnd_afull",   if_almost_full,  (mcnt >= AFULL) ? 1 : 0);
      check("rnd_aempty",  if_almost_empty, (mcnt <= AEMPTY) ? 1 : 0);
    end
    if_write = 1'b0; if_read = 1'b0;
    if_write_ce = 1'b1; if_read_ce = 1'b1;

    // Bring occupancy to 9, then reset with a push in flight
    while (q.size() > 0) begin
      d = q.pop_front();
      pop_expect("pre_rst_drain", d);
    end
    for (int i = 0; i < 9; i++) push_word(32'h500 + DW'(i));
    check("pre_rst_count", if_num_data_valid, 9);
    reset = 1'b1; if_write = 1'b1; if_din = 32'h77;
    step();
    reset = 1'b0; if_write = 1'b0;
    check("mrst_count",   if_num_data_valid, 0);
    check("mrst_empty_n", if_empty_n, 0);
    check("mrst_full_n",  if_full_n, 0);
    step();
    check("mrst_rel_full_n", if_full_n, 1);
    push_word(32'h3);
    push_word(32'h4);
    check("post_count", if_num_data_valid, 2);
    pop_expect("post_rd0", 32'h3);
    pop_expect("post_rd1", 32'h4);
    check("post_empty_n", if_empty_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
